multicycle_control_fsm: RTL and testbench

//  Moore control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and writeback.

---
 rtl/multicycle_control_fsm.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle MIPS datapath, with a retired-instruction counter.
// Optional memory wait states are enabled by defining MC_MEM_WAIT_EN.
module multicycle_control_fsm #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               zero_ext,
  output logic [2:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [3:0]         state,
  output logic               instr_done,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTYPE_EX = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDI_EX  = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_ANDI_EX  = 4'd11;
  localparam logic [3:0] S_IMM_WB   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       mem_ok;
  logic       op_legal;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_J: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPE_EX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_ANDI:      state_d = S_ANDI_EX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // IR still holds the lw/sw opcode here, so it selects read vs write.
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (mem_ok) state_d = S_MEMWB;
      S_MEMWR:    if (mem_ok) state_d = S_FETCH;
      S_RTYPE_EX: state_d = S_ALUWB;
      S_ADDI_EX,
      S_ANDI_EX:  state_d = S_IMM_WB;
      S_MEMWB, S_ALUWB, S_IMM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // All control outputs are forced low while reset is held.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    zero_ext      = 1'b0;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = mem_ok;
          pc_write  = mem_ok;
          alu_src_b = 2'b01;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          illegal   = !op_legal;
        end
        S_MEMADR, S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ANDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          zero_ext  = 1'b1;
          alu_op    = 3'b011;
        end
        S_MEMRD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
        end
        S_MEMWR: begin
          i_or_d     = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ok;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_ALUWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_IMM_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_RTYPE_EX: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b010;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 3'b001;
          pc_source     = 2'b01;
          pc_write_cond = 1'b1;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_source  = 2'b10;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           instr_count <= '0;
    else if (instr_done) instr_count <= instr_count + 1'b1;
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench for multicycle_control_fsm (default build, COUNT_W=4).
// Expected per-cycle output records come from an instruction-level state-sequence model.
module tb_multicycle_control_fsm;

  localparam int CW = 4;
  localparam int W  = 28;

  logic          clk;
  logic          reset;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic          mem_to_reg, reg_dst, reg_write, alu_src_a, zero_ext;
  logic [1:0]    alu_src_b, pc_source;
  logic [2:0]    alu_op;
  logic [3:0]    state;
  logic          instr_done, illegal;
  logic [CW-1:0] instr_count;

  multicycle_control_fsm #(.COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .zero_ext(zero_ext),
    .alu_op(alu_op), .pc_source(pc_source), .state(state),
    .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  bit mon_en = 1'b0;
  logic [CW-1:0] cnt = '0;

  // Control vector for one state, straight from the state output table.
  function automatic logic [17:0] ctrl_of(input int st);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ze;
    logic [1:0] asb, psrc;
    logic [2:0] aop;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ze} = '0;
    asb = 2'b00; psrc = 2'b00; aop = 3'b000;
    case (st)
      0:  begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2, 9: begin asa = 1; asb = 2'b10; end
      11: begin asa = 1; asb = 2'b10; ze = 1; aop = 3'b011; end
      3:  begin iod = 1; mr = 1; end
      5:  begin iod = 1; mw = 1; end
      4:  begin m2r = 1; rw = 1; end
      7:  begin rd = 1; rw = 1; end
      12: rw = 1;
      6:  begin asa = 1; aop = 3'b010; end
      8:  begin asa = 1; aop = 3'b001; psrc = 2'b01; pwc = 1; end
      10: begin psrc = 2'b10; pw = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, ze, aop, psrc};
  endfunction

  function automatic logic [W-1:0] rec(input int st, input bit done, input bit ill,
                                       input logic [CW-1:0] c);
    return {4'(st), ctrl_of(st), done, ill, c};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100,
      6'b001000, 6'b001100, 6'b000010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // driver tasks
  task automatic run_instr(input logic [5:0] op);
    int seq[$];
    bit ok;
    ok = is_legal(op);
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b000100: seq = '{0, 1, 8};
      6'b001000: seq = '{0, 1, 9, 12};
      6'b001100: seq = '{0, 1, 11, 12};
      6'b000010: seq = '{0, 1, 10};
      default:   seq = '{0, 1};
    endcase
    for (int i = 0; i < seq.size(); i++)
      exp_q.push_back(rec(seq[i], ok && (i == seq.size() - 1), !ok && (seq[i] == 1), cnt));
    opcode    = op;
    mem_ready = 1'($urandom_range(0, 1));
    repeat (seq.size()) @(posedge clk);
    #1;
    if (ok) cnt = cnt + 1'b1;
  endtask

  task automatic reset_mid_memrd();
    exp_q.push_back(rec(0, 0, 0, cnt));
    exp_q.push_back(rec(1, 0, 0, cnt));
    exp_q.push_back(rec(2, 0, 0, cnt));
    exp_q.push_back(rec(3, 0, 0, cnt));
    opcode = 6'b100011;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    cnt   = '0;
    #1;
    checks++;
    if ({state, mem_read, i_or_d, mem_write, reg_write} !== 8'h00)
      $display("FAIL reset_async: got state=%0d mem_read=%b i_or_d=%b mem_write=%b reg_write=%b required all 0",
               state, mem_read, i_or_d, mem_write, reg_write);
    else passes++;
    exp_q.push_back('0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // monitor: every cycle the DUT presents a new Moore output vector
  always @(negedge clk) begin
    if (mon_en) begin
      logic [W-1:0] act, e;
      act = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, zero_ext, alu_op,
             pc_source, instr_done, illegal, instr_count};
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL cycle_underrun: got output %h required an expected record", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e)
          $display("FAIL cycle_check t=%0t: got %h required %h (state got %0d required %0d)",
                   $time, act, e, act[W-1 -: 4], e[W-1 -: 4]);
        else passes++;
      end
    end
  end

  initial begin
    logic [5:0] legal_ops [7];
    logic [5:0] op;
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b001100, 6'b000010};
    reset     = 1'b1;
    opcode    = 6'b000000;
    mem_ready = 1'b0;
    exp_q.push_back('0);
    exp_q.push_back('0);
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(6'b100011);
    run_instr(6'b000000);
    run_instr(6'b000100);
    run_instr(6'b001100);
    run_instr(6'b111111);
    run_instr(6'b001000);
    run_instr(6'b101011);
    run_instr(6'b000010);

    reset_mid_memrd();

    for (int i = 0; i < 17; i++) run_instr(6'b000010);
    #1;
    checks++;
    if (instr_count !== 4'd1)
      $display("FAIL count_wrap: got %0d required 1", instr_count);
    else passes++;

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 6)];
      end
      run_instr(op);
    end

    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL queue_drain: got %0d leftover records required 0", exp_q.size());
    else passes++;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
